// File: rtl/route_pkg.sv
// Shared definitions for the packet sequencer in front of the 1-to-3 routing demux:
// FSM states, destination codes and header field positions.
package route_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        DROP = 2'd2
    } route_state_t;

    localparam logic [1:0] DEST_IMG  = 2'd0;
    localparam logic [1:0] DEST_WGT  = 2'd1;
    localparam logic [1:0] DEST_BIAS = 2'd2;
    localparam logic [1:0] DEST_BAD  = 2'd3;

    localparam int unsigned HDR_DEST_MSB = 15;
    localparam int unsigned HDR_DEST_LSB = 14;
    localparam int unsigned HDR_LEN_MSB  = 13;
    localparam int unsigned HDR_LEN_LSB  = 0;
    localparam int unsigned LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    // Destination code to write-strobe bit; DEST_BAD maps to no strobe.
    function automatic logic [2:0] dest_onehot(input logic [1:0] dest);
        return (dest == DEST_BAD) ? 3'b000 : (3'b001 << dest);
    endfunction

endpackage

// File: rtl/demux_route_ctrl_if.sv
// Stream-in / demux-out bundle for demux_route_ctrl. master = bridge/integration side,
// slave = the sequencer itself.
interface demux_route_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [15:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic              out_stall;
    logic [15:0]       data_out;
    logic [1:0]        sel;
    logic [2:0]        wr_en;
    logic [ADDR_W-1:0] addr_out;
    logic [2:0]        done;
    logic              err;
    logic              clr_err;

    modport master (
        output in_data, in_valid, out_stall, clr_err,
        input  in_ready, data_out, sel, wr_en, addr_out, done, err
    );

    modport slave (
        input  in_data, in_valid, out_stall, clr_err,
        output in_ready, data_out, sel, wr_en, addr_out, done, err
    );
endinterface

// File: rtl/demux_route_ctrl.sv
// Packet sequencer: parses a header per packet and drives registered data/sel/wr_en/addr
// into the combinational 1-to-3 demux, with per-destination done pulses and sticky err.
module demux_route_ctrl
    import route_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MAX_LEN = 784
) (
    input  logic               clk,
    input  logic               reset_n,
    demux_route_ctrl_if.slave  bus
);

    route_state_t      state;
    logic [ADDR_W-1:0] idx;
    logic [LEN_W-1:0]  rem;
    logic [1:0]        dest_q;

    logic              accept;
    logic [1:0]        hdr_dest;
    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_bad;
    logic              last_word;

    assign bus.in_ready = !bus.out_stall && reset_n;
    assign accept       = bus.in_valid && bus.in_ready;

    assign hdr_dest  = bus.in_data[HDR_DEST_MSB:HDR_DEST_LSB];
    assign hdr_len   = bus.in_data[HDR_LEN_MSB:HDR_LEN_LSB];
    assign hdr_bad   = (hdr_dest == DEST_BAD) || (hdr_len > LEN_W'(MAX_LEN));
    // rem counts words still owed; rem==1 is the idx==len-1 word, and unlike idx it
    // stays exact for oversize packets in DROP.
    assign last_word = (rem == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= HDR;
            idx          <= '0;
            rem          <= '0;
            dest_q       <= '0;
            bus.data_out <= '0;
            bus.sel      <= '0;
            bus.wr_en    <= '0;
            bus.addr_out <= '0;
            bus.done     <= '0;
            bus.err      <= 1'b0;
        end else begin
            bus.wr_en <= '0;
            bus.done  <= '0;
            if (bus.clr_err) begin
                bus.err <= 1'b0;
            end
            if (accept) begin
                unique case (state)
                    HDR: begin
                        if (hdr_bad) begin
                            bus.err <= 1'b1;
                            rem     <= hdr_len;
                            if (hdr_len != '0) begin
                                state <= DROP;
                            end
                        end else if (hdr_len == '0) begin
                            bus.done <= dest_onehot(hdr_dest);
                        end else begin
                            dest_q <= hdr_dest;
                            rem    <= hdr_len;
                            idx    <= '0;
                            state  <= PAY;
                        end
                    end
                    PAY: begin
                        bus.data_out <= bus.in_data;
                        bus.sel      <= dest_q;
                        bus.wr_en    <= dest_onehot(dest_q);
                        bus.addr_out <= idx;
                        idx          <= idx + 1'b1;
                        rem          <= rem - 1'b1;
                        if (last_word) begin
                            bus.done <= dest_onehot(dest_q);
                            state    <= HDR;
                        end
                    end
                    DROP: begin
                        rem <= rem - 1'b1;
                        if (last_word) begin
                            state <= HDR;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Bench for demux_route_ctrl: directed packet scenarios with literal checks, then random
// traffic, all scored every cycle against a words-remaining packet model.
module tb_demux_route_ctrl;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned MAX_LEN = 784;

    logic clk;
    logic reset_n;

    demux_route_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    demux_route_ctrl #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the packet is described by how many words are still owed after its header.
    bit                started = 0;
    int                m_rem   = 0;
    int                m_idx   = 0;
    int                m_dest  = 0;
    bit                m_drop  = 0;
    logic [15:0]       exp_data;
    logic [1:0]        exp_sel;
    logic [2:0]        exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [2:0]        exp_done;
    logic              exp_err;

    always @(posedge clk) begin
        int d;
        int l;
        if (!reset_n) begin
            started  = 1;
            m_rem    = 0;
            m_idx    = 0;
            m_dest   = 0;
            m_drop   = 0;
            exp_data = '0;
            exp_sel  = '0;
            exp_wr   = '0;
            exp_addr = '0;
            exp_done = '0;
            exp_err  = 1'b0;
        end else begin
            exp_wr   = '0;
            exp_done = '0;
            if (bus.clr_err) exp_err = 1'b0;
            if (bus.in_valid && !bus.out_stall) begin
                if (m_rem == 0) begin
                    d = int'(bus.in_data[15:14]);
                    l = int'(bus.in_data[13:0]);
                    if (d == 3 || l > int'(MAX_LEN)) begin
                        exp_err = 1'b1;
                        m_rem   = l;
                        m_drop  = 1;
                    end else if (l == 0) begin
                        exp_done = 3'b001 << d;
                    end else begin
                        m_dest = d;
                        m_rem  = l;
                        m_idx  = 0;
                        m_drop = 0;
                    end
                end else begin
                    if (!m_drop) begin
                        exp_data = bus.in_data;
                        exp_sel  = 2'(m_dest);
                        exp_wr   = 3'b001 << m_dest;
                        exp_addr = ADDR_W'(m_idx);
                        m_idx    = m_idx + 1;
                        if (m_rem == 1) exp_done = 3'b001 << m_dest;
                    end
                    m_rem = m_rem - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_rdy;
        if (started) begin
            exp_rdy = !bus.out_stall && reset_n;
            n_cmp++;
            if ({bus.data_out, bus.sel, bus.wr_en, bus.addr_out, bus.done, bus.err, bus.in_ready}
                !== {exp_data, exp_sel, exp_wr, exp_addr, exp_done, exp_err, exp_rdy}) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t: got data=%h sel=%0d wr=%b addr=%0d done=%b err=%b rdy=%b, want data=%h sel=%0d wr=%b addr=%0d done=%b err=%b rdy=%b",
                         $time, bus.data_out, bus.sel, bus.wr_en, bus.addr_out, bus.done, bus.err,
                         bus.in_ready, exp_data, exp_sel, exp_wr, exp_addr, exp_done, exp_err, exp_rdy);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic send(input logic [15:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_write(input string nm, input logic [2:0] wr, input int addr,
                             input logic [2:0] dn);
        chk({nm, ".wr_en"}, 32'(bus.wr_en), 32'(wr));
        chk({nm, ".addr"}, 32'(bus.addr_out), 32'(addr));
        chk({nm, ".done"}, 32'(bus.done), 32'(dn));
    endtask

    initial begin
        logic [1:0]  d;
        logic [13:0] l;
        int          r;

        reset_n       = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_stall = 1'b0;
        bus.clr_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outputs", {bus.data_out, 2'b0, bus.sel, 1'b0, bus.wr_en, 1'b0, bus.done},
            32'h0);
        chk("reset.addr_err", {bus.addr_out, bus.err}, 0);
        reset_n = 1'b1;

        // 1: three words to the image buffer
        send(16'h0003);
        chk("t1.hdr_no_write", 32'(bus.wr_en), 0);
        send(16'hAAAA);
        chk_write("t1.w0", 3'b001, 0, 3'b000);
        chk("t1.w0.data", 32'(bus.data_out), 32'hAAAA);
        send(16'hBBBB);
        chk_write("t1.w1", 3'b001, 1, 3'b000);
        send(16'hCCCC);
        chk_write("t1.w2", 3'b001, 2, 3'b001);
        chk("t1.w2.sel", 32'(bus.sel), 0);

        // 2: back-to-back packets to weight then bias
        send(16'h4002);
        send(16'h1111);
        chk_write("t2.w0", 3'b010, 0, 3'b000);
        send(16'h2222);
        chk_write("t2.w1", 3'b010, 1, 3'b010);
        send(16'h8001);
        chk("t2.hdr2_no_write", 32'(bus.wr_en), 0);
        send(16'h3333);
        chk_write("t2.b0", 3'b100, 0, 3'b100);
        chk("t2.b0.sel", 32'(bus.sel), 2);

        // 3: bad destination dropped, err sticky until cleared
        send(16'hC002);
        chk("t3.err_set", 32'(bus.err), 1);
        send(16'h5555);
        chk("t3.drop0", 32'(bus.wr_en), 0);
        send(16'h6666);
        chk("t3.drop1", 32'(bus.wr_en | bus.done), 0);
        send(16'h0001);
        send(16'h7777);
        chk_write("t3.good", 3'b001, 0, 3'b001);
        chk("t3.err_sticky", 32'(bus.err), 1);
        bus.clr_err = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_err = 1'b0;
        chk("t3.err_cleared", 32'(bus.err), 0);

        // 4: oversize packet, one word past MAX_LEN
        send(16'h0311);
        chk("t4.err_set", 32'(bus.err), 1);
        for (int i = 0; i < 785; i++) send(16'($urandom));
        chk("t4.last_drop", 32'(bus.wr_en | bus.done), 0);
        send(16'h0001);
        send(16'h9999);
        chk_write("t4.next_pkt", 3'b001, 0, 3'b001);
        bus.clr_err = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_err = 1'b0;

        // 5: stall in the middle of a 4-word packet
        send(16'h4004);
        send(16'hA000);
        send(16'hA001);
        chk_write("t5.w1", 3'b010, 1, 3'b000);
        bus.out_stall = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hA002;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t5.stall_ready", 32'(bus.in_ready), 0);
            chk("t5.stall_wr", 32'(bus.wr_en), 0);
        end
        bus.out_stall = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk_write("t5.w2", 3'b010, 2, 3'b000);
        send(16'hA003);
        chk_write("t5.w3", 3'b010, 3, 3'b010);

        // 6: reset after two of five words
        send(16'h0005);
        send(16'hB000);
        send(16'hB001);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("t6.reset_out", {bus.data_out, 2'b0, bus.sel, 1'b0, bus.wr_en, 1'b0, bus.done}, 0);
        chk("t6.reset_addr", 32'(bus.addr_out), 0);
        send(16'h4001);
        chk("t6.hdr_no_write", 32'(bus.wr_en), 0);
        send(16'hB002);
        chk_write("t6.w0", 3'b010, 0, 3'b010);

        // Random traffic; headers are chosen whenever the model expects one.
        for (int c = 0; c < 4000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_stall = ($urandom_range(0, 7) == 0);
            bus.clr_err   = ($urandom_range(0, 31) == 0);
            reset_n       = ($urandom_range(0, 499) != 0);
            if (m_rem == 0) begin
                r = int'($urandom_range(0, 99));
                d = 2'($urandom_range(0, 2));
                l = 14'($urandom_range(1, 9));
                if (r < 8)       l = '0;
                else if (r < 14) d = 2'd3;
                else if (r < 17) l = 14'(MAX_LEN + $urandom_range(1, 3));
                else if (r < 19) l = 14'(MAX_LEN);
                bus.in_data = {d, l};
            end else begin
                bus.in_data = 16'($urandom);
            end
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
